bin_morph_3x3: RTL and testbench
================================

Name: bin_morph_3x3

Overview:
- Binarizing 3x3 morphological filter, directly upstream of the VGA output controller; drives its `morfologico` input.
- Thresholds a grey pixel stream and keeps two 1-bit line buffers.
- Applies erosion or dilation over a 3x3 window and emits all-ones/all-zeros 10-bit pixels, one output per valid input pixel.

Parameters:
- H_ACT, 640, active pixels per line; column counter wrap point and line buffer depth.
- CNT_W, 11, width of the column counter; must satisfy 2^CNT_W > H_ACT.

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  asynchronous active-low reset.
- iSOF  in  1  start-of-frame strobe, asserted together with the first valid pixel of a frame.
- iDVAL  in  1  input pixel valid.
- iDATA  in  10  grey pixel.
- iTHRESH  in  10  binarization threshold; sampled every valid cycle.
- iOP  in  1  0 = erosion, 1 = dilation; sampled only on iSOF.
- oDVAL  out  1  output pixel valid.
- oDATA  out  10  10'h3FF (white) or 10'h000 (black).
- oWHITE_CNT  out  19  number of white output pixels in the previous complete frame.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - oDVAL=0, oDATA=0, oWHITE_CNT=0.
  - Column/row counters = 0, op register = 0 (erosion), running white count = 0.
  - Line buffer contents are don't-care.
- Binarization: b = (iDATA >= iTHRESH), unsigned compare.
- Counters advance only on iDVAL=1:
  - col increments and wraps H_ACT-1 -> 0; row increments on that wrap.
  - row saturates at 2, since only row<2 matters.
- iSOF with iDVAL=1: the pixel is position (0,0). Counters are forced so that the pixel is processed as col=0,row=0. op register <= iOP; oWHITE_CNT <= running count; running count restarts from this pixel's contribution.
- iSOF without iDVAL: same counter/op/count actions; no pixel is processed.
- Window:
  - Three 3-bit column shift registers (row r-2 from line buffer 1 output, row r-1 from line buffer 0 output, row r = b).
  - Shift on iDVAL only.
  - Line buffer 0 writes b at address col; line buffer 1 writes line buffer 0's read data at address col (read-before-write, same address).
- Output for input pixel at (r,c): 3x3 op over rows r-2..r, cols c-2..c, i.e. center (r-1,c-1).
  - Output image is shifted one row and one column relative to input.
  - Erosion: AND of 9 bits. Dilation: OR of 9 bits.
  - Forced to 0 when row<2 or col<2, for both ops.
- Latency: oDVAL/oDATA registered exactly 1 clock after the accepted iDVAL cycle. oDVAL=0 otherwise; oDATA holds its last value when oDVAL=0.
- Gaps in iDVAL (blanking): no state change except the output register dropping oDVAL.
- Running white count increments per output with oDATA=3FF and saturates at 2^19-1.
- Frame of unexpected length (iSOF early or late): no error; counters simply restart on iSOF.
- iOP changes mid-frame are ignored until the next iSOF.
- Mid-frame reset: all state cleared; output stays black/invalid until the stream resumes. The first two rows after reset are masked because row restarts at 0.

Decomposition:
- Shared package holds:
  - WHITE = 10'h3FF, BLACK = 10'h000.
  - OP_ERODE = 1'b0, OP_DILATE = 1'b1.
  - The frame count width.
- One sub-module, line_buf_1b:
  - Parameter DEPTH=H_ACT.
  - Single-port synchronous RAM with registered read-before-write, enable = iDVAL, address = col.
  - Instantiated twice.

Test Plan (H_ACT=8):
1. All-white 8x6 frame, iTHRESH=0, iOP=0 -> rows 0-1 and cols 0-1 of every row output 000; others 3FF; next iSOF latches oWHITE_CNT=24.
2. Single white pixel at (3,4), erosion, iTHRESH=512, white=iDATA 1000, rest 0 -> all outputs 000; oWHITE_CNT=0 after next iSOF.
3. Same frame with iOP=1 asserted on iSOF -> outputs 3FF exactly for input positions r in 3..5, c in 4..6 (9 pixels); oWHITE_CNT=9.
4. iOP toggled 0->1 mid-frame -> current frame keeps erosion results; dilation applies from the next frame.
5. iDVAL with 3-cycle gaps between pixels -> oDVAL pulses exactly 1 clock after each valid input; results identical to scenario 3.
6. iRST_N low for 2 cycles in row 3 -> outputs 000/oDVAL=0 immediately (asynchronous); oWHITE_CNT=0; restart with iSOF reproduces scenario 1.

Source files
------------

// File: rtl/bin_morph_3x3_pkg.sv
// Shared constants and helpers for the binarizing 3x3 morphological filter.
package bin_morph_3x3_pkg;

    localparam int unsigned FCNT_W = 19;

    localparam logic [9:0] WHITE = 10'h3FF;
    localparam logic [9:0] BLACK = 10'h000;

    typedef enum logic {
        OP_ERODE  = 1'b0,
        OP_DILATE = 1'b1
    } morph_op_e;

    function automatic logic [FCNT_W-1:0] sat_add(input logic [FCNT_W-1:0] a, input logic inc);
        if (inc && (a != '1)) begin
            return a + FCNT_W'(1);
        end
        return a;
    endfunction

endpackage

// File: rtl/bin_morph_3x3_line_buf.sv
// One-bit-wide single-port line memory; the read returns the contents before the write.
module line_buf_1b #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Old word is registered by the caller's window shift registers on the same edge.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bin_morph_3x3.sv
// Thresholds a grey stream, keeps two 1-bit line buffers and erodes/dilates over 3x3.
module bin_morph_3x3
    import bin_morph_3x3_pkg::*;
#(
    parameter int unsigned H_ACT = 640,
    parameter int unsigned CNT_W = 11
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSOF,
    input  logic              iDVAL,
    input  logic [9:0]        iDATA,
    input  logic [9:0]        iTHRESH,
    input  logic              iOP,
    output logic              oDVAL,
    output logic [9:0]        oDATA,
    output logic [FCNT_W-1:0] oWHITE_CNT
);

    localparam int unsigned LB_AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;

    logic [CNT_W-1:0]  col_q, col_d, col_eff;
    logic [1:0]        row_q, row_d, row_eff;
    morph_op_e         op_q, op_d, op_eff;
    logic [1:0]        w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic              odval_q, odval_d;
    logic [9:0]        odata_q, odata_d;
    logic [FCNT_W-1:0] run_q, run_d, wcnt_q, wcnt_d;

    logic       pix_b, lb0_rd, lb1_rd, last_col, masked, hit, res, white;
    logic [8:0] win;

    // A start-of-frame forces the current pixel to (0,0) before anything else sees it.
    assign col_eff  = iSOF ? '0 : col_q;
    assign row_eff  = iSOF ? '0 : row_q;
    assign op_eff   = iSOF ? morph_op_e'(iOP) : op_q;
    assign pix_b    = (iDATA >= iTHRESH);
    assign last_col = (col_eff == CNT_W'(H_ACT - 1));

    line_buf_1b #(.DEPTH(H_ACT), .AW(LB_AW)) u_lb0 (
        .clk_i   (iCLK),
        .en_i    (iDVAL),
        .addr_i  (col_eff[LB_AW-1:0]),
        .wdata_i (pix_b),
        .rdata_o (lb0_rd)
    );

    line_buf_1b #(.DEPTH(H_ACT), .AW(LB_AW)) u_lb1 (
        .clk_i   (iCLK),
        .en_i    (iDVAL),
        .addr_i  (col_eff[LB_AW-1:0]),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Rows r-2, r-1, r; each row is {col c-2, col c-1, col c}.
    assign win    = {w2_q, lb1_rd, w1_q, lb0_rd, w0_q, pix_b};
    assign masked = (row_eff < 2'd2) || (col_eff < CNT_W'(2));
    assign hit    = (op_eff == OP_DILATE) ? (|win) : (&win);
    assign res    = hit && !masked;
    assign white  = iDVAL && res;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        op_d    = op_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        odval_d = iDVAL;
        odata_d = odata_q;
        wcnt_d  = wcnt_q;
        run_d   = sat_add(run_q, white);

        if (iSOF) begin
            col_d  = '0;
            row_d  = '0;
            op_d   = morph_op_e'(iOP);
            wcnt_d = run_q;
            run_d  = FCNT_W'(white);
        end

        if (iDVAL) begin
            w0_d    = {w0_q[0], pix_b};
            w1_d    = {w1_q[0], lb0_rd};
            w2_d    = {w2_q[0], lb1_rd};
            odata_d = res ? WHITE : BLACK;
            if (last_col) begin
                col_d = '0;
                row_d = (row_eff == 2'd2) ? row_eff : row_eff + 2'd1;
            end else begin
                col_d = col_eff + CNT_W'(1);
                row_d = row_eff;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col_q   <= '0;
            row_q   <= '0;
            op_q    <= OP_ERODE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            odval_q <= 1'b0;
            odata_q <= BLACK;
            run_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            op_q    <= op_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            odval_q <= odval_d;
            odata_q <= odata_d;
            run_q   <= run_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign oDVAL      = odval_q;
    assign oDATA      = odata_q;
    assign oWHITE_CNT = wcnt_q;

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Directed bench for bin_morph_3x3 with an image-level reference model (H_ACT=8).
module tb_bin_morph_3x3;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iSOF = 1'b0;
    logic        iDVAL = 1'b0;
    logic [9:0]  iDATA = '0;
    logic [9:0]  iTHRESH = '0;
    logic        iOP = 1'b0;
    logic        oDVAL;
    logic [9:0]  oDATA;
    logic [18:0] oWHITE_CNT;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;

    bin_morph_3x3 #(.H_ACT(8), .CNT_W(4)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iSOF       (iSOF),
        .iDVAL      (iDVAL),
        .iDATA      (iDATA),
        .iTHRESH    (iTHRESH),
        .iOP        (iOP),
        .oDVAL      (oDVAL),
        .oDATA      (oDATA),
        .oWHITE_CNT (oWHITE_CNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the binarized frame as a 2D image, outputs from the 3x3 rule.
    logic       img [0:31][0:7];
    int         mcol = 0;
    int         mrow = 0;
    logic       mop = 1'b0;
    int         run_cnt = 0;
    int         m_cnt = 0;
    logic       m_dval = 1'b0;
    logic [9:0] m_data = '0;
    logic       m_out;

    function automatic logic model_pix(input int r, input int c, input logic op);
        logic any_w, all_w;
        if (r < 2 || c < 2) return 1'b0;
        any_w = 1'b0;
        all_w = 1'b1;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                any_w = any_w | img[r-dr][c-dc];
                all_w = all_w & img[r-dr][c-dc];
            end
        end
        return op ? any_w : all_w;
    endfunction

    initial forever begin
        @(posedge iCLK or negedge iRST_N);
        if (!iRST_N) begin
            mcol = 0; mrow = 0; mop = 1'b0; run_cnt = 0; m_cnt = 0;
            m_dval = 1'b0; m_data = '0;
        end else begin
            if (iSOF) begin
                mop = iOP; m_cnt = run_cnt; run_cnt = 0; mcol = 0; mrow = 0;
            end
            m_dval = iDVAL;
            if (iDVAL) begin
                img[mrow][mcol] = (iDATA >= iTHRESH);
                m_out = model_pix(mrow, mcol, mop);
                m_data = m_out ? 10'h3FF : 10'h000;
                if (m_out && run_cnt < 524287) run_cnt++;
                mcol++;
                if (mcol == 8) begin
                    mcol = 0;
                    if (mrow < 31) mrow++;
                end
            end
        end
    end

    initial forever begin
        @(negedge iCLK);
        if (check_en) begin
            chk("odval", int'(oDVAL), int'(m_dval));
            chk("odata", int'(oDATA), int'(m_data));
            chk("white_cnt", int'(oWHITE_CNT), m_cnt);
        end
    end

    task automatic cyc(input logic sof, input logic dv, input logic [9:0] d,
                       input logic [9:0] th, input logic op);
        @(negedge iCLK);
        iSOF = sof; iDVAL = dv; iDATA = d; iTHRESH = th; iOP = op;
    endtask

    // kind 0: all white with threshold 0; kind 1: single white pixel at (3,4).
    task automatic send_frame(input int kind, input logic op_sof, input logic op_mid,
                              input int gap, input int stop_r, input int stop_c);
        logic [9:0] d, th;
        logic op;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (kind == 0) begin
                    d = 10'((r * 8 + c) * 13); th = 10'd0;
                end else begin
                    d = (r == 3 && c == 4) ? 10'd1000 : 10'd0; th = 10'd512;
                end
                op = (r == 0 && c == 0) ? op_sof : op_mid;
                cyc(r == 0 && c == 0, 1'b1, d, th, op);
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, d, th, op);
            end
        end
    endtask

    task automatic end_frame(input logic op);
        cyc(1'b1, 1'b0, 10'd0, 10'd0, op);
        cyc(1'b0, 1'b0, 10'd0, 10'd0, op);
    endtask

    initial begin
        repeat (2) @(negedge iCLK);
        chk("reset_odval", int'(oDVAL), 0);
        chk("reset_odata", int'(oDATA), 0);
        chk("reset_cnt", int'(oWHITE_CNT), 0);
        check_en = 1'b1;
        iRST_N = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);

        send_frame(0, 1'b0, 1'b0, 0, 99, 99);
        end_frame(1'b0);
        chk("s1_all_white_cnt", int'(oWHITE_CNT), 24);

        send_frame(1, 1'b0, 1'b0, 0, 99, 99);
        end_frame(1'b0);
        chk("s2_erode_dot_cnt", int'(oWHITE_CNT), 0);

        send_frame(1, 1'b1, 1'b1, 0, 99, 99);
        end_frame(1'b1);
        chk("s3_dilate_dot_cnt", int'(oWHITE_CNT), 9);

        send_frame(1, 1'b0, 1'b1, 0, 99, 99);
        end_frame(1'b1);
        chk("s4_midframe_op_cnt", int'(oWHITE_CNT), 0);
        send_frame(1, 1'b1, 1'b1, 0, 99, 99);
        end_frame(1'b1);
        chk("s4_next_frame_cnt", int'(oWHITE_CNT), 9);

        send_frame(1, 1'b1, 1'b1, 3, 99, 99);
        end_frame(1'b1);
        chk("s5_gapped_cnt", int'(oWHITE_CNT), 9);

        send_frame(0, 1'b0, 1'b0, 0, 3, 4);
        iDVAL = 1'b0; iSOF = 1'b0;
        @(posedge iCLK);
        #1;
        chk("s6_pre_reset_odata", int'(oDATA), 10'h3FF);
        iRST_N = 1'b0;
        #1;
        chk("s6_async_odval", int'(oDVAL), 0);
        chk("s6_async_odata", int'(oDATA), 0);
        chk("s6_async_cnt", int'(oWHITE_CNT), 0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        cyc(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        send_frame(0, 1'b0, 1'b0, 0, 99, 99);
        end_frame(1'b0);
        chk("s6_restart_cnt", int'(oWHITE_CNT), 24);

        repeat (2) @(negedge iCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
